// File: rtl/core_bus_pkg.sv
// Shared encodings for the core data-bus to AHB-Lite bridge: transfer types, sizes, FSM states.
package core_bus_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_ERR
  } bus_state_e;

  // Reserved size code behaves as a word transfer.
  function automatic logic [1:0] size_norm(input logic [1:0] size);
    return (size == SIZE_RSVD) ? SIZE_WORD : size;
  endfunction

  function automatic logic [1:0] align_mask(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 2'b00;
      SIZE_HALF: return 2'b01;
      default:   return 2'b11;
    endcase
  endfunction

  function automatic logic [2:0] hsize_of(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return HSIZE_BYTE;
      SIZE_HALF: return HSIZE_HALF;
      default:   return HSIZE_WORD;
    endcase
  endfunction

endpackage

// File: rtl/core_ahb_bridge_if.sv
// Core data-bus request port plus AHB-Lite master signals, as seen by the bridge (slave)
// and by its environment (master).
interface core_ahb_bridge_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              ahb_rd_en;
  logic              ahb_wr_en;
  logic [ADDR_W-1:0] ahb_addr;
  logic [1:0]        ahb_size;
  logic [31:0]       ahb_wr_data;
  logic [31:0]       ahb_rd_data;
  logic              ahb_rd_vld;
  logic              ahb_busy;
  logic              bus_err;
  logic              req_drop;

  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [3:0]        HPROT;
  logic [31:0]       HWDATA;
  logic [31:0]       HRDATA;
  logic              HREADY;
  logic              HRESP;

  modport slave (
    input  ahb_rd_en, ahb_wr_en, ahb_addr, ahb_size, ahb_wr_data,
    output ahb_rd_data, ahb_rd_vld, ahb_busy, bus_err, req_drop,
    output HADDR, HTRANS, HWRITE, HSIZE, HPROT, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport master (
    output ahb_rd_en, ahb_wr_en, ahb_addr, ahb_size, ahb_wr_data,
    input  ahb_rd_data, ahb_rd_vld, ahb_busy, bus_err, req_drop,
    input  HADDR, HTRANS, HWRITE, HSIZE, HPROT, HWDATA,
    output HRDATA, HREADY, HRESP
  );

endinterface

// File: rtl/core_bus_lane.sv
// Byte-lane steering: replicate narrow write data across HWDATA, extract and zero-extend read data.
module core_bus_lane
  import core_bus_pkg::*;
(
  input  logic [1:0]        size,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] hrdata,
  output logic [DATA_W-1:0] wdata_rep_c,
  output logic [DATA_W-1:0] rdata_ext_c
);

  always_comb begin
    wdata_rep_c = wdata;
    rdata_ext_c = hrdata;
    case (size)
      SIZE_BYTE: begin
        wdata_rep_c = {4{wdata[7:0]}};
        rdata_ext_c = {24'h0, hrdata[{addr_lo, 3'b000} +: 8]};
      end
      SIZE_HALF: begin
        wdata_rep_c = {2{wdata[15:0]}};
        rdata_ext_c = {16'h0, hrdata[{addr_lo[1], 4'b0000} +: 16]};
      end
      default: begin
        wdata_rep_c = wdata;
        rdata_ext_c = hrdata;
      end
    endcase
  end

endmodule

// File: rtl/core_ahb_bridge.sv
// Executes one core read/write request at a time as a non-pipelined AHB-Lite SINGLE transfer.
module core_ahb_bridge
  import core_bus_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter logic [3:0]  HPROT_VAL = 4'b0011,
  parameter logic [31:0] ERR_RDATA = 32'h0
) (
  input logic              clk,
  input logic              rst,
  core_ahb_bridge_if.slave bus
);

  bus_state_e        state_q, state_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [1:0]        size_q, size_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              write_q, write_d;
  logic [1:0]        htrans_q, htrans_d;
  logic [ADDR_W-1:0] haddr_q, haddr_d;
  logic              hwrite_q, hwrite_d;
  logic [2:0]        hsize_q, hsize_d;
  logic [31:0]       hwdata_q, hwdata_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic              rd_vld_q, rd_vld_d;
  logic              busy_q, busy_d;
  logic              bus_err_q, bus_err_d;
  logic              req_drop_q, req_drop_d;

  logic              req, done, err;
  logic [1:0]        req_size;
  logic [31:0]       wdata_rep_c, rdata_ext_c;

  core_bus_lane u_lane (
    .size        (size_q),
    .addr_lo     (addr_lo_q),
    .wdata       (wdata_q),
    .hrdata      (bus.HRDATA),
    .wdata_rep_c (wdata_rep_c),
    .rdata_ext_c (rdata_ext_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_lo_q  <= 2'b00;
      size_q     <= SIZE_BYTE;
      wdata_q    <= 32'h0;
      write_q    <= 1'b0;
      htrans_q   <= HTRANS_IDLE;
      haddr_q    <= '0;
      hwrite_q   <= 1'b0;
      hsize_q    <= 3'b000;
      hwdata_q   <= 32'h0;
      rd_data_q  <= 32'h0;
      rd_vld_q   <= 1'b0;
      busy_q     <= 1'b0;
      bus_err_q  <= 1'b0;
      req_drop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_lo_q  <= addr_lo_d;
      size_q     <= size_d;
      wdata_q    <= wdata_d;
      write_q    <= write_d;
      htrans_q   <= htrans_d;
      haddr_q    <= haddr_d;
      hwrite_q   <= hwrite_d;
      hsize_q    <= hsize_d;
      hwdata_q   <= hwdata_d;
      rd_data_q  <= rd_data_d;
      rd_vld_q   <= rd_vld_d;
      busy_q     <= busy_d;
      bus_err_q  <= bus_err_d;
      req_drop_q <= req_drop_d;
    end
  end

  // Next-state and registered-output logic; pulses default low, everything else holds.
  always_comb begin
    state_d    = state_q;
    addr_lo_d  = addr_lo_q;
    size_d     = size_q;
    wdata_d    = wdata_q;
    write_d    = write_q;
    htrans_d   = htrans_q;
    haddr_d    = haddr_q;
    hwrite_d   = hwrite_q;
    hsize_d    = hsize_q;
    hwdata_d   = hwdata_q;
    rd_data_d  = rd_data_q;
    busy_d     = busy_q;
    rd_vld_d   = 1'b0;
    bus_err_d  = 1'b0;
    req_drop_d = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    req        = bus.ahb_rd_en | bus.ahb_wr_en;
    req_size   = size_norm(bus.ahb_size);

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d    = ST_ADDR;
          addr_lo_d  = bus.ahb_addr[1:0];
          size_d     = req_size;
          wdata_d    = bus.ahb_wr_data;
          write_d    = bus.ahb_wr_en;
          req_drop_d = bus.ahb_rd_en & bus.ahb_wr_en;
          htrans_d   = HTRANS_NONSEQ;
          haddr_d    = bus.ahb_addr & ~ADDR_W'(align_mask(req_size));
          hwrite_d   = bus.ahb_wr_en;
          hsize_d    = hsize_of(req_size);
          busy_d     = 1'b1;
        end
      end
      ST_ADDR: begin
        req_drop_d = req;
        if (bus.HREADY) begin
          state_d  = ST_DATA;
          htrans_d = HTRANS_IDLE;
          if (write_q) hwdata_d = wdata_rep_c;
        end
      end
      ST_DATA: begin
        req_drop_d = req;
        if (bus.HREADY) begin
          done = 1'b1;
          err  = bus.HRESP;
        end else if (bus.HRESP) begin
          state_d = ST_ERR;
        end
      end
      ST_ERR: begin
        req_drop_d = req;
        if (bus.HREADY) begin
          done = 1'b1;
          err  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (done) begin
      state_d   = ST_IDLE;
      busy_d    = 1'b0;
      bus_err_d = err;
      if (!write_q) begin
        rd_vld_d  = 1'b1;
        rd_data_d = err ? ERR_RDATA : rdata_ext_c;
      end
    end
  end

  assign bus.HTRANS      = htrans_q;
  assign bus.HADDR       = haddr_q;
  assign bus.HWRITE      = hwrite_q;
  assign bus.HSIZE       = hsize_q;
  assign bus.HPROT       = HPROT_VAL;
  assign bus.HWDATA      = hwdata_q;
  assign bus.ahb_rd_data = rd_data_q;
  assign bus.ahb_rd_vld  = rd_vld_q;
  assign bus.ahb_busy    = busy_q;
  assign bus.bus_err     = bus_err_q;
  assign bus.req_drop    = req_drop_q;

endmodule
